vga_ram_arbiter: RTL and testbench
==================================

// Module: vga_ram_arbiter
// PURPOSE
//  Shares one single-port 1024x32 on-chip RAM (byte-enabled, 1-cycle read latency)
//  between two requesters: M0 = FFT bin writer/reader, M1 = VGA bar-fetch reader.
//  M1 has priority for display timing. A starvation counter guarantees M0 progress.
//  Sits between the FFT/VGA engines and the RAM's chipselect/write/address port.
// PARAMETERS
//  ADDR_W    10  RAM word-address width
//  DATA_W    32  RAM data width
//  BE_W       4  byte-enable width (DATA_W/8)
//  MAX_WAIT   4  consecutive M0 denials before M0 is forced a grant (1..15)
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  pause           in   1       stall: no grants, ram_clken low
//  mN_req          in   1       N=0,1: request valid this cycle
//  mN_write        in   1       1=write, 0=read
//  mN_addr         in   ADDR_W  word address
//  mN_be           in   BE_W    byte enables (writes only)
//  mN_wdata        in   DATA_W  write data
//  mN_gnt          out  1       request accepted this cycle (combinational)
//  mN_rvalid       out  1       read data valid (registered)
//  mN_rdata        out  DATA_W  read data (= ram_readdata)
//  ram_address     out  ADDR_W  to RAM address
//  ram_byteenable  out  BE_W    to RAM byteenable
//  ram_chipselect  out  1       to RAM chipselect
//  ram_write       out  1       to RAM write
//  ram_writedata   out  DATA_W  to RAM writedata
//  ram_clken       out  1       to RAM clken (= ~pause)
//  ram_readdata    in   DATA_W  from RAM, valid 1 cycle after read is issued
// BEHAVIOUR
//  - Reset, sampled on clk: wait_cnt=0, mN_rvalid=0, last_owner=M1, force=0.
//    While reset=1: mN_gnt=0, ram_chipselect=0, ram_write=0.
//  - Grant, evaluated each cycle, combinational from the inputs and registered state:
//    pause=1 -> no grant.
//    Else if force=1 and m0_req=1 -> M0.
//    Else if m1_req=1 -> M1.
//    Else if m0_req=1 -> M0.
//    Else idle.
//  - At most one gnt per cycle. The granted master's addr/be/wdata/write drive the ram_* outputs.
//    ram_chipselect = any gnt. ram_write = gnt & write.
//    Idle: ram_* data and address hold the M1 mux value, ram_chipselect=0.
//  - Read reads always drive ram_byteenable = all-ones.
//  - Starvation counter:
//    m0_req & ~m0_gnt & ~pause -> wait_cnt++.
//    m0_gnt, or ~m0_req -> wait_cnt=0.
//    force = (wait_cnt == MAX_WAIT). force clears on the M0 grant.
//    During pause, wait_cnt holds.
//  - Read return: mN_rvalid(t+1) = mN_gnt(t) & ~mN_write(t) & ~pause(t+1).
//    If pause(t+1)=1, the pending rvalid is held in a 1-deep pending flag per master.
//    That pending rvalid is issued on the first cycle with pause=0.
//    RAM output is frozen by clken, so the data is preserved.
//  - Writes return nothing. A write followed by a read of the same address is granted
//    back-to-back; the read returns the new data. Read-during-write on the same cycle
//    cannot occur, because the port is single-issue.
//  - Requesters must hold req/addr/data stable until gnt. Withdrawing req before gnt is
//    legal and resets wait_cnt.
//  - Reset mid-operation: in-flight rvalid and pending flags are dropped. No RAM write
//    issues during reset.
// TESTING
//  1. M1-only reads, addr 0..1023 back-to-back. Required: m1_gnt every cycle, and
//     m1_rvalid 1 cycle later with the RAM contents. Address 1023->0 must wrap cleanly.
//  2. M0 write 0xDEADBEEF, be=4'b0101, to addr 5, then M0 read addr 5. Required: rdata
//     bytes 0 and 2 updated, bytes 1 and 3 unchanged, m0_rvalid 1 cycle after the read gnt.
//  3. m0_req and m1_req held continuously, MAX_WAIT=4. Required: grants follow the pattern
//     M1,M1,M1,M1,M0 repeating. wait_cnt never exceeds 4.
//  4. Read granted at t, pause=1 at t+1..t+3. Required: no rvalid during the pause, no new
//     gnt, then rvalid with the correct data at t+4.
//  5. Reset asserted the cycle after an M1 read gnt. Required: m1_rvalid stays 0, wait_cnt=0,
//     and the first post-reset grant follows the priority rules.
//  6. Random M0/M1 traffic against a scoreboard RAM model. Required: no double gnt, no lost
//     request, and all rdata matching the model.

Source files
------------

// File: rtl/vga_ram_arbiter.sv
// vga_ram_arbiter: shares one single-port, byte-enabled, 1-cycle-latency RAM between
// the FFT bin engine (M0) and the VGA bar fetcher (M1). M1 wins by default; a
// starvation counter forces an M0 grant after MAX_WAIT consecutive denials.
module vga_ram_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BE_W     = 4,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    // M0: FFT bin writer/reader
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    // M1: VGA bar-fetch reader
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    // RAM port
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam int unsigned CntW = 4;

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            force_grant;
    // Per-master read-return flag; holds across pause so it doubles as the pending flag.
    logic [1:0]      rd_q, rd_d;
    logic            sel_write;

    assign force_grant = (wait_cnt_q == CntW'(MAX_WAIT));

    // Fixed-priority grant with starvation override.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset && !pause) begin
            if (force_grant && m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end
        end
    end

    // RAM port mux; idle cycles present the M1 request fields with chipselect low.
    always_comb begin
        sel_write      = m0_gnt ? m0_write : m1_write;
        ram_address    = m0_gnt ? m0_addr : m1_addr;
        ram_writedata  = m0_gnt ? m0_wdata : m1_wdata;
        ram_byteenable = '1;
        if (sel_write) begin
            ram_byteenable = m0_gnt ? m0_be : m1_be;
        end
        ram_chipselect = m0_gnt | m1_gnt;
        ram_write      = (m0_gnt & m0_write) | (m1_gnt & m1_write);
        ram_clken      = ~pause;
    end

    // Next-state for the starvation counter and read-return flags; both freeze on pause.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        rd_d       = rd_q;
        if (!pause) begin
            if (m0_gnt || !m0_req) begin
                wait_cnt_d = '0;
            end else if (!force_grant) begin
                wait_cnt_d = wait_cnt_q + CntW'(1);
            end
            rd_d = {m1_gnt & ~m1_write, m0_gnt & ~m0_write};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rd_q       <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
        end
    end

    // Read data comes straight from the RAM; clken keeps it frozen across a pause.
    assign m0_rvalid = rd_q[0] & ~pause & ~reset;
    assign m1_rvalid = rd_q[1] & ~pause & ~reset;
    assign m0_rdata  = ram_readdata;
    assign m1_rdata  = ram_readdata;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Bench for vga_ram_arbiter: behavioural RAM, reference model checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_vga_ram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W = 4;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pause = 1'b0;
    logic              m0_req = 1'b0, m0_write = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [BE_W-1:0]   m0_be = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_write = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [BE_W-1:0]   m1_be = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect, ram_write, ram_clken;
    logic [DATA_W-1:0] ram_writedata, ram_readdata;

    int total = 0;
    int bad = 0;

    vga_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_be(m0_be),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_be(m1_be),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'h1122_3300 ^ 32'(i);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with clock enable and 1-cycle read latency.
    logic [31:0] ram_mem [1024];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            end else begin
                ram_q <= ram_mem[ram_address];
            end
        end
    end
    assign ram_readdata = ram_q;

    // Reference model: expected grants, RAM port, and read returns from the rules.
    logic [31:0] model_mem [1024];
    int          denials = 0;
    bit          pend [2];
    logic [31:0] pdata [2];
    int          starve0 = 0, starve1 = 0;

    always @(negedge clk) begin
        bit e0, e1, ev0, ev1, ew;
        logic [9:0]  ea;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        e0 = 0; e1 = 0;
        if (!reset && !pause) begin
            if (denials >= MAX_WAIT && m0_req) e0 = 1;
            else if (m1_req) e1 = 1;
            else if (m0_req) e0 = 1;
        end
        ew  = e0 ? m0_write : m1_write;
        ea  = e0 ? m0_addr : m1_addr;
        ebe = ew ? (e0 ? m0_be : m1_be) : 4'hF;
        ewd = e0 ? m0_wdata : m1_wdata;
        check("m0_gnt", m0_gnt, e0);
        check("m1_gnt", m1_gnt, e1);
        check("ram_chipselect", ram_chipselect, e0 | e1);
        check("ram_write", ram_write, (e0 | e1) & ew);
        check("ram_clken", ram_clken, !pause);
        if (e0 || e1) begin
            check("ram_address", ram_address, ea);
            check("ram_byteenable", ram_byteenable, ebe);
            if (ew) check("ram_writedata", ram_writedata, ewd);
        end
        ev0 = pend[0] && !pause && !reset;
        ev1 = pend[1] && !pause && !reset;
        check("m0_rvalid", m0_rvalid, ev0);
        check("m1_rvalid", m1_rvalid, ev1);
        if (ev0) check("m0_rdata", m0_rdata, pdata[0]);
        if (ev1) check("m1_rdata", m1_rdata, pdata[1]);
        // Observed progress bounds: M0 waits at most MAX_WAIT live cycles, M1 at most one.
        if (!reset && !pause) begin
            if (m0_req && !m0_gnt) begin
                starve0++;
                check("m0_starve_bound", 32'(starve0 <= MAX_WAIT), 1);
            end else starve0 = 0;
            if (m1_req && !m1_gnt) begin
                starve1++;
                check("m1_starve_bound", 32'(starve1 <= 1), 1);
            end else starve1 = 0;
        end else if (reset) begin
            starve0 = 0; starve1 = 0;
        end
        // Advance model to the next cycle.
        if (reset) begin
            denials = 0;
            pend[0] = 0; pend[1] = 0;
        end else if (!pause) begin
            pend[0] = e0 && !m0_write;
            pend[1] = e1 && !m1_write;
            if (pend[0]) pdata[0] = model_mem[m0_addr];
            if (pend[1]) pdata[1] = model_mem[m1_addr];
            if ((e0 || e1) && ew)
                for (int b = 0; b < 4; b++)
                    if (ebe[b]) model_mem[ea][b*8 +: 8] = ewd[b*8 +: 8];
            if (!m0_req || e0) denials = 0;
            else denials++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g, rv;
        bit g0, g1;
        logic [9:0] pat3;
        logic [4:0] pat5;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i]   = init_word(i);
            model_mem[i] = init_word(i);
        end
        pend[0] = 0; pend[1] = 0;
        pdata[0] = '0; pdata[1] = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", ram_chipselect, 0);
        check("rst_rvalid1", m1_rvalid, 0);
        next_cycle();
        reset = 1'b0;

        // 1: M1 back-to-back reads over the whole space, wrapping 1023 -> 0.
        g = 0; rv = 0;
        m1_req = 1'b1; m1_write = 1'b0;
        for (int i = 0; i < 1025; i++) begin
            m1_addr = 10'(i);
            @(negedge clk);
            if (m1_gnt) g++;
            if (m1_rvalid) rv++;
            if (i == 1024) check("t1_wrap_rdata", m1_rdata, 32'h1122_30FF);
            next_cycle();
        end
        m1_req = 1'b0;
        @(negedge clk);
        if (m1_rvalid) rv++;
        check("t1_wrap0_rdata", m1_rdata, 32'h1122_3300);
        check("t1_gnt_count", g, 1025);
        check("t1_rvalid_count", rv, 1025);
        next_cycle();

        // 2: byte-enabled write to addr 5, then read it back.
        m0_req = 1'b1; m0_write = 1'b1; m0_addr = 10'd5; m0_be = 4'b0101;
        m0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t2_wr_gnt", m0_gnt, 1);
        next_cycle();
        m0_write = 1'b0; m0_be = 4'b0000;
        @(negedge clk);
        check("t2_rd_gnt", m0_gnt, 1);
        next_cycle();
        m0_req = 1'b0;
        @(negedge clk);
        check("t2_rvalid", m0_rvalid, 1);
        check("t2_rdata", m0_rdata, 32'h11AD_33EF);
        next_cycle();

        // 3: both masters requesting continuously -> M1 x4, M0, repeating.
        pat3 = 10'b10_0001_0000;
        m0_req = 1'b1; m0_addr = 10'd7;
        m1_req = 1'b1; m1_addr = 10'd9;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_m0_gnt", m0_gnt, pat3[k]);
            check("t3_m1_gnt", m1_gnt, !pat3[k]);
            next_cycle();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) next_cycle();

        // 4: read granted, then three paused cycles; data appears once pause drops.
        m1_req = 1'b1; m1_addr = 10'd100;
        @(negedge clk);
        check("t4_gnt", m1_gnt, 1);
        next_cycle();
        m1_req = 1'b0; pause = 1'b1; m0_req = 1'b1; m0_addr = 10'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_pause_rvalid", m1_rvalid, 0);
            check("t4_pause_gnt", m0_gnt, 0);
            next_cycle();
        end
        pause = 1'b0; m0_req = 1'b0;
        @(negedge clk);
        check("t4_rvalid", m1_rvalid, 1);
        check("t4_rdata", m1_rdata, 32'h1122_3364);
        next_cycle();
        repeat (2) next_cycle();

        // 5: reset right after an M1 read grant drops the return and clears wait_cnt.
        m1_req = 1'b1; m1_addr = 10'd200;
        m0_req = 1'b1; m0_addr = 10'd201;
        @(negedge clk);
        check("t5_pre_gnt", m1_gnt, 1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_rvalid", m1_rvalid, 0);
        check("t5_rst_cs", ram_chipselect, 0);
        next_cycle();
        reset = 1'b0;
        pat5 = 5'b10000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) check("t5_post_rvalid", m1_rvalid, 0);
            check("t5_m0_gnt", m0_gnt, pat5[k]);
            next_cycle();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) next_cycle();

        // 6: random traffic on a small address window, with occasional pauses.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            next_cycle();
            if (!m0_req || g0) begin
                m0_req   = ($urandom_range(0, 99) < 50);
                m0_write = 1'($urandom_range(0, 1));
                m0_addr  = 10'($urandom_range(0, 15));
                m0_be    = 4'($urandom_range(0, 15));
                m0_wdata = $urandom;
            end
            if (!m1_req || g1) begin
                m1_req   = ($urandom_range(0, 99) < 60);
                m1_write = ($urandom_range(0, 99) < 20);
                m1_addr  = 10'($urandom_range(0, 15));
                m1_be    = 4'($urandom_range(0, 15));
                m1_wdata = $urandom;
            end
            pause = ($urandom_range(0, 9) == 0);
        end
        m0_req = 1'b0; m1_req = 1'b0; pause = 1'b0;
        repeat (3) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
